// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin per-packet arbiter feeding one uart_sender
//
// Ports:
//   clk, reset_n          clock (uart_sender domain), asynchronous active-low reset
//   req_valid/data/last   per-requester byte stream; byte i on req_data[8i+7:8i]
//   req_ready             byte accepted when req_valid & req_ready
//   ready_to_send         uart_sender idle
//   data_to_send          byte presented to uart_sender (held between bytes)
//   data_to_send_ready    one-cycle send strobe
//   grant_valid/grant_id  packet in progress and its owner
//   ack_err, err_clr      sticky acknowledge-watchdog error and its clear
//   pkt_count             completed packets, wrapping
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 ready_to_send,
    output logic [7:0]           data_to_send,
    output logic                 data_to_send_ready,
    output logic                 grant_valid,
    output logic [1:0]           grant_id,
    output logic                 ack_err,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     pkt_count
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STROBE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      last_grant;
    logic            last_flag;
    logic [TO_W-1:0] ack_cnt;

    logic            pick_found;
    logic [1:0]      pick_id;
    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            accept;
    logic            ack_timeout;

    // Round-robin pick: scan offsets 1..NUM_REQ from the previous owner so
    // the previous owner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && req_valid[i] &&
                    ((int'(last_grant) + k) % NUM_REQ == i)) begin
                    pick_found = 1'b1;
                    pick_id    = 2'(i);
                end
            end
        end
    end

    // Granted requester's stream
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign accept      = (state == S_FETCH) && sel_valid && ready_to_send;
    // Fires on the ACK_TIMEOUT-th cycle spent in WAIT_ACK with the sender still idle
    assign ack_timeout = (state == S_WAIT_ACK) && ready_to_send &&
                         (ack_cnt == TO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_next         = state;
        req_ready          = '0;
        data_to_send_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) state_next = S_FETCH;
            end
            S_FETCH: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id == 2'(i)) req_ready[i] = ready_to_send;
                end
                if (accept) state_next = S_STROBE;
            end
            S_STROBE: begin
                data_to_send_ready = 1'b1;
                state_next         = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!ready_to_send || ack_timeout) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (ready_to_send) state_next = last_flag ? S_IDLE : S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            grant_valid  <= 1'b0;
            grant_id     <= 2'd0;
            last_grant   <= 2'(NUM_REQ - 1);
            data_to_send <= 8'h00;
            last_flag    <= 1'b0;
            ack_cnt      <= '0;
            ack_err      <= 1'b0;
            pkt_count    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (accept) begin
                        data_to_send <= sel_data;
                        last_flag    <= sel_last;
                    end
                end
                S_STROBE: begin
                    ack_cnt <= '0;
                end
                S_WAIT_ACK: begin
                    ack_cnt <= ack_cnt + TO_W'(1);
                end
                S_WAIT_DONE: begin
                    if (ready_to_send && last_flag) begin
                        grant_valid <= 1'b0;
                        last_grant  <= grant_id;
                        pkt_count   <= pkt_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            // A watchdog set in the same cycle as a clear takes priority
            if (ack_timeout) begin
                ack_err <= 1'b1;
            end else if (err_clr) begin
                ack_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int AT = 16;
    localparam int CW = 16;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           ready_to_send;
    logic [7:0]     data_to_send;
    logic           data_to_send_ready;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic           ack_err;
    logic           err_clr;
    logic [CW-1:0]  pkt_count;

    uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(AT), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .ready_to_send(ready_to_send),
        .data_to_send(data_to_send), .data_to_send_ready(data_to_send_ready),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .ack_err(ack_err), .err_clr(err_clr), .pkt_count(pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main-sequence owned
    logic [8:0] ld [N][$];
    int         load_seq [N];
    int         flush_seq;
    bit [N-1:0] hold;
    bit         stuck;
    bit         rgap;
    int         busy_lo;
    int         busy_hi;
    // driver owned
    logic [8:0] pq [N][$];
    int         load_seen [N];
    int         pop_cnt [N];
    int         flush_seen;
    int         stb_seen;
    int         busy_cnt;
    bit [N-1:0] mid;
    bit         gap;
    logic [8:0] e_pop;
    logic [8:0] e_head;
    // monitor owned
    int         fire_cnt [N];
    int         stb_cnt;
    int         stb_cyc;
    int         cyc;
    int         viol;
    logic [9:0] tx_log [$];

    // Monitor: samples handshakes at the active edge (pre-update values)
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) fire_cnt[i] = fire_cnt[i] + 1;
        if (data_to_send_ready) begin
            stb_cnt = stb_cnt + 1;
            stb_cyc = cyc;
            tx_log.push_back({grant_id, data_to_send});
        end
        if (reset_n) begin
            if (req_ready != '0 && (!grant_valid || req_ready != N'(1 << grant_id))) viol = viol + 1;
            if (data_to_send_ready && !grant_valid) viol = viol + 1;
        end
    end

    // Driver: requesters and uart_sender model, updated on the falling edge
    always @(negedge clk) begin
        if (flush_seen != flush_seq) begin
            flush_seen = flush_seq;
            for (int i = 0; i < N; i++) begin
                pq[i].delete();
                pop_cnt[i] = fire_cnt[i];
            end
            mid      = '0;
            busy_cnt = 0;
            stb_seen = stb_cnt;
        end
        for (int i = 0; i < N; i++) begin
            if (load_seen[i] != load_seq[i]) begin
                load_seen[i] = load_seq[i];
                for (int k = 0; k < ld[i].size(); k++) pq[i].push_back(ld[i][k]);
            end
            while (pop_cnt[i] != fire_cnt[i]) begin
                pop_cnt[i] = pop_cnt[i] + 1;
                e_pop  = pq[i].pop_front();
                mid[i] = !e_pop[8];
            end
        end
        if (stb_seen != stb_cnt) begin
            stb_seen = stb_cnt;
            if (!stuck) busy_cnt = $urandom_range(busy_hi, busy_lo);
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        ready_to_send = (busy_cnt == 0);
        for (int i = 0; i < N; i++) begin
            gap = mid[i] && (hold[i] || (rgap && $urandom_range(0, 2) == 0));
            if (pq[i].size() > 0 && !gap) begin
                e_head             = pq[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e_head[7:0];
                req_last[i]        = e_head[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    end

    int         n_chk;
    int         n_err;
    int         mlast;
    int         exp_pkts;
    int         log_base;
    logic [9:0] exp_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (pq[i].size() != 0 || load_seen[i] != load_seq[i] || pop_cnt[i] != fire_cnt[i])
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int t = 0;
        bit idle = 1'b0;
        while (!idle && t < budget) begin
            tick(1);
            t++;
            idle = !grant_valid && busy_cnt == 0 && stb_seen == stb_cnt && all_empty();
        end
        chk($sformatf("%s settles", nm), int'(idle), 1);
    endtask

    task automatic wait_tx(input string nm, input int n, input int budget);
        int t = 0;
        while (tx_log.size() - log_base < n && t < budget) begin
            tick(1);
            t++;
        end
        chk($sformatf("%s strobes reached", nm), int'(tx_log.size() - log_base >= n), 1);
    endtask

    task automatic clear_stage();
        for (int i = 0; i < N; i++) ld[i].delete();
    endtask

    task automatic stage(input int id, input int len, input int base);
        for (int k = 0; k < len; k++) ld[id].push_back({(k == len - 1), 8'(base + k)});
    endtask

    task automatic load(input int id);
        load_seq[id]++;
    endtask

    // Reference: whole packets leave in round-robin order among requesters
    // that still have packets, starting after the previous owner.
    task automatic model_run();
        logic [8:0] tmp [N][$];
        logic [8:0] e;
        int pick;
        bit more = 1'b1;
        for (int i = 0; i < N; i++) tmp[i] = ld[i];
        while (more) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && tmp[(mlast + k) % N].size() > 0) pick = (mlast + k) % N;
            if (pick < 0) begin
                more = 1'b0;
            end else begin
                do begin
                    e = tmp[pick].pop_front();
                    exp_q.push_back({2'(pick), e[7:0]});
                end while (!e[8]);
                mlast = pick;
                exp_pkts++;
            end
        end
    endtask

    task automatic compare_log(input string tag);
        chk($sformatf("%s strobe count", tag), tx_log.size() - log_base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (log_base + k < tx_log.size())
                chk($sformatf("%s id:byte %0d", tag, k), int'(tx_log[log_base + k]), int'(exp_q[k]));
        log_base = tx_log.size();
        exp_q.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk($sformatf("%s req_ready", tag), int'(req_ready), 0);
        chk($sformatf("%s data_to_send", tag), int'(data_to_send), 0);
        chk($sformatf("%s data_to_send_ready", tag), int'(data_to_send_ready), 0);
        chk($sformatf("%s grant_valid", tag), int'(grant_valid), 0);
        chk($sformatf("%s grant_id", tag), int'(grant_id), 0);
        chk($sformatf("%s ack_err", tag), int'(ack_err), 0);
        chk($sformatf("%s pkt_count", tag), int'(pkt_count), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush_seq++;
        tick(2);
        reset_n  = 1'b1;
        log_base = tx_log.size();
        exp_q.delete();
        mlast    = N - 1;
        exp_pkts = 0;
    endtask

    typedef struct {
        int id;
        int len;
        int base;
        int busy;
        int exp_cnt;
    } vec_t;

    vec_t vt [4];
    int   t;
    int   np;

    initial begin
        vt[0] = '{0, 3, 'h41, 20, 1};
        vt[1] = '{1, 1, 'hA0, 3, 2};
        vt[2] = '{2, 2, 'hFE, 1, 3};
        vt[3] = '{0, 4, 'h10, 2, 4};

        reset_n = 1'b0;
        err_clr = 1'b0;
        hold    = '0;
        stuck   = 1'b0;
        rgap    = 1'b0;
        busy_lo = 4;
        busy_hi = 4;
        mlast   = N - 1;
        tick(3);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        tick(2);
        chk_reset_vals("after release");

        // Single-packet table
        for (int v = 0; v < 4; v++) begin
            busy_lo = vt[v].busy;
            busy_hi = vt[v].busy;
            clear_stage();
            stage(vt[v].id, vt[v].len, vt[v].base);
            for (int k = 0; k < vt[v].len; k++)
                exp_q.push_back({2'(vt[v].id), 8'(vt[v].base + k)});
            mlast = vt[v].id;
            exp_pkts++;
            load(vt[v].id);
            wait_idle($sformatf("vec%0d", v), 2000);
            compare_log($sformatf("vec%0d", v));
            chk($sformatf("vec%0d pkt_count", v), int'(pkt_count), vt[v].exp_cnt);
            chk($sformatf("vec%0d grant_valid", v), int'(grant_valid), 0);
        end

        // Simultaneous requests from reset, two rounds
        do_reset();
        busy_lo = 5;
        busy_hi = 5;
        for (int r = 0; r < 2; r++) begin
            clear_stage();
            stage(0, 2, 'h50 + 4 * r);
            stage(1, 2, 'h60 + 4 * r);
            model_run();
            load(0);
            load(1);
            wait_idle($sformatf("simul%0d", r), 2000);
            compare_log($sformatf("simul%0d", r));
        end
        chk("simul pkt_count", int'(pkt_count), 4);

        // Requester 1 arrives mid-packet
        clear_stage();
        stage(0, 4, 'h20);
        stage(1, 2, 'h80);
        model_run();
        load(0);
        wait_tx("midarr", 2, 500);
        load(1);
        wait_idle("midarr", 2000);
        compare_log("midarr");

        // Acknowledge watchdog
        stuck = 1'b1;
        clear_stage();
        stage(0, 1, 'h5A);
        model_run();
        load(0);
        t = 0;
        while (!ack_err && t < 300) begin
            tick(1);
            t++;
        end
        chk("wdog fires", int'(ack_err), 1);
        chk("wdog latency", cyc - stb_cyc, AT);
        wait_idle("wdog", 500);
        compare_log("wdog");
        chk("wdog sticky", int'(ack_err), 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr clears", int'(ack_err), 0);
        // set beats a concurrent clear
        err_clr = 1'b1;
        clear_stage();
        stage(1, 1, 'h66);
        model_run();
        load(1);
        t = 0;
        while (!ack_err && t < 300) begin
            tick(1);
            t++;
        end
        chk("wdog set wins over clear", int'(ack_err), 1);
        tick(1);
        err_clr = 1'b0;
        chk("wdog held clear", int'(ack_err), 0);
        wait_idle("wdog2", 500);
        compare_log("wdog2");
        stuck = 1'b0;

        // Asynchronous reset in WAIT_DONE of byte 2 of 4
        busy_lo = 8;
        busy_hi = 8;
        clear_stage();
        stage(1, 4, 'h71);
        load(1);
        wait_tx("rst", 2, 500);
        tick(3);
        chk("rst pre grant", int'(grant_valid), 1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async reset");
        flush_seq++;
        tick(2);
        reset_n  = 1'b1;
        log_base = tx_log.size();
        exp_q.delete();
        mlast    = N - 1;
        exp_pkts = 0;
        clear_stage();
        stage(0, 1, 'h30);
        stage(1, 1, 'h31);
        model_run();
        load(0);
        load(1);
        wait_idle("post rst", 1000);
        compare_log("post rst");
        chk("post rst pkt_count", int'(pkt_count), 2);

        // Requester 0 pauses 50 cycles mid-packet
        busy_lo = 3;
        busy_hi = 3;
        hold[0] = 1'b1;
        clear_stage();
        stage(0, 3, 'hC1);
        model_run();
        load(0);
        wait_tx("gap", 1, 500);
        tick(50);
        chk("gap no strobe", tx_log.size() - log_base, 1);
        chk("gap grant held", int'(grant_valid), 1);
        chk("gap grant_id", int'(grant_id), 0);
        hold[0] = 1'b0;
        wait_idle("gap", 1000);
        compare_log("gap");
        chk("gap pkt_count", int'(pkt_count), exp_pkts % 65536);

        // Randomized traffic against the reference
        rgap    = 1'b1;
        busy_lo = 1;
        busy_hi = 6;
        for (int r = 0; r < 8; r++) begin
            clear_stage();
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) stage(i, $urandom_range(1, 4), $urandom_range(0, 255));
            end
            model_run();
            for (int i = 0; i < N; i++) load(i);
            wait_idle($sformatf("rand%0d", r), 4000);
            compare_log($sformatf("rand%0d", r));
            chk($sformatf("rand%0d pkt_count", r), int'(pkt_count), exp_pkts % 65536);
        end
        rgap = 1'b0;

        chk("protocol invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
